// File: rtl/add_arb_pkg.sv
// rtl/add_arb_pkg.sv - shared widths and stage payload types for the add-slot arbiter
package add_arb_pkg;

    localparam int ADD_WIDTH  = 64;
    localparam int ADD_DEST_W = 5;
    localparam int ADD_SLOT_W = 3;

    typedef struct packed {
        logic [ADD_WIDTH-1:0]  a;
        logic [ADD_WIDTH-1:0]  b;
        logic                  sub;
        logic [ADD_DEST_W-1:0] dest;
        logic [ADD_SLOT_W-1:0] slot;
    } add_req_t;

    typedef struct packed {
        logic [ADD_WIDTH-1:0]  sum;
        logic                  cout;
        logic                  ovf;
        logic [ADD_DEST_W-1:0] dest;
        logic [ADD_SLOT_W-1:0] slot;
    } add_res_t;

endpackage

// File: rtl/prefix_adder64.sv
// rtl/prefix_adder64.sv - 64-bit Kogge-Stone parallel-prefix adder with carry-in
module prefix_adder64 (
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  logic        cin_i,
    output logic [63:0] sum_o,
    output logic        cout_o
);

    logic [6:0][63:0] g_lvl;
    logic [6:0][63:0] p_lvl;
    logic [64:0]      carry;

    always_comb begin
        g_lvl    = '0;
        p_lvl    = '0;
        g_lvl[0] = a_i & b_i;
        p_lvl[0] = a_i ^ b_i;
        for (int l = 0; l < 6; l++) begin
            for (int i = 0; i < 64; i++) begin
                if (i >= (1 << l)) begin
                    g_lvl[l+1][i] = g_lvl[l][i] | (p_lvl[l][i] & g_lvl[l][i-(1<<l)]);
                    p_lvl[l+1][i] = p_lvl[l][i] & p_lvl[l][i-(1<<l)];
                end else begin
                    g_lvl[l+1][i] = g_lvl[l][i];
                    p_lvl[l+1][i] = p_lvl[l][i];
                end
            end
        end
        // Group terms span [i:0]; carry-in folds in as one extra prefix step.
        carry[0] = cin_i;
        for (int i = 0; i < 64; i++) begin
            carry[i+1] = g_lvl[6][i] | (p_lvl[6][i] & cin_i);
        end
        sum_o  = p_lvl[0] ^ carry[63:0];
        cout_o = carry[64];
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant search starting at ptr with wrap-around
module rr_arbiter #(
    parameter  int NUM_SLOTS = 4,
    localparam int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic [NUM_SLOTS-1:0] req_i,
    input  logic [SLOT_W-1:0]    ptr_i,
    output logic [NUM_SLOTS-1:0] gnt_o,
    output logic [SLOT_W-1:0]    gnt_idx_o
);

    logic found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            int j;
            j = int'(ptr_i) + k;
            if (j >= NUM_SLOTS) begin
                j = j - NUM_SLOTS;
            end
            if (!found && req_i[j]) begin
                found     = 1'b1;
                gnt_o[j]  = 1'b1;
                gnt_idx_o = SLOT_W'(j);
            end
        end
    end

endmodule

// File: rtl/add_slot_arbiter.sv
// rtl/add_slot_arbiter.sv - round-robin sharing of one prefix adder across VLIW issue slots
module add_slot_arbiter
    import add_arb_pkg::*;
#(
    parameter  int NUM_SLOTS = 4,
    parameter  int WIDTH     = ADD_WIDTH,
    parameter  int DEST_W    = ADD_DEST_W,
    localparam int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SLOTS-1:0]        req_valid,
    output logic [NUM_SLOTS-1:0]        req_ready,
    input  logic [NUM_SLOTS*WIDTH-1:0]  req_a,
    input  logic [NUM_SLOTS*WIDTH-1:0]  req_b,
    input  logic [NUM_SLOTS-1:0]        req_sub,
    input  logic [NUM_SLOTS*DEST_W-1:0] req_dest,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [SLOT_W-1:0]           res_slot,
    output logic [DEST_W-1:0]           res_dest,
    output logic [WIDTH-1:0]            res_sum,
    output logic                        res_cout,
    output logic                        res_ovf
);

    logic [NUM_SLOTS-1:0] gnt;
    logic [SLOT_W-1:0]    gnt_idx;
    logic [SLOT_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                 s1_valid_q;
    add_req_t             s1_q, s1_d;
    logic                 res_valid_q;
    add_res_t             res_q, res_d;
    logic                 s2_load, s1_load, xfer;
    logic [WIDTH-1:0]     b_eff, add_sum;
    logic                 add_cout;
    logic                 unused_slot_msbs;

    rr_arbiter #(.NUM_SLOTS(NUM_SLOTS)) u_arb (
        .req_i     (req_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign s2_load = !res_valid_q || res_ready;
    assign s1_load = !s1_valid_q || s2_load;
    // Reset overrides any handshake so a request seen during reset is never consumed.
    assign req_ready = (s1_load && !rst) ? gnt : '0;
    assign xfer      = |req_ready;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            rr_ptr_d = (gnt_idx == SLOT_W'(NUM_SLOTS - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_comb begin
        s1_d = s1_q;
        if (xfer) begin
            s1_d.a    = req_a[gnt_idx*WIDTH +: WIDTH];
            s1_d.b    = req_b[gnt_idx*WIDTH +: WIDTH];
            s1_d.sub  = req_sub[gnt_idx];
            s1_d.dest = req_dest[gnt_idx*DEST_W +: DEST_W];
            s1_d.slot = ADD_SLOT_W'(gnt_idx);
        end
    end

    assign b_eff = s1_q.sub ? ~s1_q.b : s1_q.b;

    prefix_adder64 u_add (
        .a_i    (s1_q.a),
        .b_i    (b_eff),
        .cin_i  (s1_q.sub),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_comb begin
        res_d      = res_q;
        res_d.sum  = add_sum;
        res_d.cout = add_cout;
        res_d.ovf  = (s1_q.a[WIDTH-1] == b_eff[WIDTH-1]) && (add_sum[WIDTH-1] != s1_q.a[WIDTH-1]);
        res_d.dest = s1_q.dest;
        res_d.slot = s1_q.slot;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            res_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (s1_load) begin
                s1_valid_q <= xfer;
                s1_q       <= s1_d;
            end
            if (s2_load) begin
                res_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    res_q <= res_d;
                end
            end
        end
    end

    assign res_valid        = res_valid_q;
    assign res_slot         = res_q.slot[SLOT_W-1:0];
    assign res_dest         = res_q.dest;
    assign res_sum          = res_q.sum;
    assign res_cout         = res_q.cout;
    assign res_ovf          = res_q.ovf;
    assign unused_slot_msbs = ^res_q.slot;

endmodule

// File: tb/tb_add_slot_arbiter.sv
// tb/tb_add_slot_arbiter.sv - directed self-checking bench for add_slot_arbiter
module tb_add_slot_arbiter;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int D  = 5;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_sub;
    logic [N*D-1:0] req_dest;
    logic           res_valid;
    logic           res_ready;
    logic [SW-1:0]  res_slot;
    logic [D-1:0]   res_dest;
    logic [W-1:0]   res_sum;
    logic           res_cout;
    logic           res_ovf;

    int checks = 0;
    int errors = 0;

    add_slot_arbiter #(.NUM_SLOTS(N), .WIDTH(W), .DEST_W(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .req_dest  (req_dest),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_slot  (res_slot),
        .res_dest  (res_dest),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_ovf   (res_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int s, input logic [63:0] a, input logic [63:0] b,
                           input logic sub, input logic [4:0] dest);
        req_valid[s]      = 1'b1;
        req_a[s*W +: W]   = a;
        req_b[s*W +: W]   = b;
        req_sub[s]        = sub;
        req_dest[s*D +: D] = dest;
    endtask

    task automatic clr_req(input int s);
        req_valid[s] = 1'b0;
    endtask

    logic [63:0] va [5];
    logic [63:0] vb [5];
    logic        vs [5];
    logic [63:0] esum [5];
    logic        ecout [5];
    logic        eovf [5];
    logic [63:0] held_sum;

    initial begin
        va[0] = 64'h0;                 vb[0] = 64'h1;                 vs[0] = 1'b1;
        esum[0] = 64'hFFFF_FFFF_FFFF_FFFF; ecout[0] = 1'b0; eovf[0] = 1'b0;
        va[1] = 64'h7FFF_FFFF_FFFF_FFFF; vb[1] = 64'h1;               vs[1] = 1'b0;
        esum[1] = 64'h8000_0000_0000_0000; ecout[1] = 1'b0; eovf[1] = 1'b1;
        va[2] = 64'hFFFF_FFFF_FFFF_FFFF; vb[2] = 64'hFFFF_FFFF_FFFF_FFFF; vs[2] = 1'b0;
        esum[2] = 64'hFFFF_FFFF_FFFF_FFFE; ecout[2] = 1'b1; eovf[2] = 1'b0;
        va[3] = 64'h5;                 vb[3] = 64'h3;                 vs[3] = 1'b1;
        esum[3] = 64'h2;               ecout[3] = 1'b1; eovf[3] = 1'b0;
        va[4] = 64'h8000_0000_0000_0000; vb[4] = 64'h1;               vs[4] = 1'b1;
        esum[4] = 64'h7FFF_FFFF_FFFF_FFFF; ecout[4] = 1'b1; eovf[4] = 1'b1;

        rst = 1'b1; res_ready = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0; req_sub = '0; req_dest = '0;
        step(); step();
        rst = 1'b0;
        #1;
        check("rst_valid", res_valid, 0);
        check("rst_sum", res_sum, 0);
        check("rst_slot", res_slot, 0);
        check("rst_dest", res_dest, 0);
        check("rst_flags", {res_cout, res_ovf}, 0);
        check("rst_ready", req_ready, 0);

        // Single request from slot 2: two-cycle latency, pointer moves to 3.
        set_req(2, 64'h5, 64'h3, 1'b0, 5'd7);
        #1 check("t1_ready", req_ready, 4'b0100);
        step();
        clr_req(2);
        #1 check("t1_lat1_valid", res_valid, 0);
        step();
        check("t1_valid", res_valid, 1);
        check("t1_sum", res_sum, 64'h8);
        check("t1_cout", res_cout, 0);
        check("t1_ovf", res_ovf, 0);
        check("t1_slot", res_slot, 2);
        check("t1_dest", res_dest, 7);
        set_req(0, 64'h1, 64'h1, 1'b0, 5'd1);
        set_req(3, 64'd10, 64'd20, 1'b0, 5'd3);
        #1 check("t1_ptr3_ready", req_ready, 4'b1000);
        step();
        clr_req(0); clr_req(3);
        #1 check("t1_drain_valid", res_valid, 0);
        step();
        check("t1b_slot", res_slot, 3);
        check("t1b_sum", res_sum, 64'd30);
        check("t1b_dest", res_dest, 3);
        step();
        #1 check("t1_empty", res_valid, 0);

        // All slots valid every cycle: grants and results rotate 0,1,2,3.
        for (int s = 0; s < N; s++) begin
            set_req(s, 64'(s*100 + 1), 64'(s + 5), 1'b0, 5'(10 + s));
        end
        for (int c = 0; c < 10; c++) begin
            if (c == 8) req_valid = '0;
            #1;
            check($sformatf("t2_ready_%0d", c), req_ready, (c < 8) ? 64'(1 << (c % 4)) : 64'h0);
            if (c >= 2) begin
                check($sformatf("t2_valid_%0d", c), res_valid, 1);
                check($sformatf("t2_slot_%0d", c), res_slot, 64'((c - 2) % 4));
                check($sformatf("t2_sum_%0d", c), res_sum, 64'(((c - 2) % 4) * 101 + 6));
                check($sformatf("t2_dest_%0d", c), res_dest, 64'(10 + (c - 2) % 4));
            end
            step();
        end
        #1 check("t2_empty", res_valid, 0);

        // Back-to-back edge-case arithmetic from slot 1.
        for (int c = 0; c < 7; c++) begin
            if (c < 5) set_req(1, va[c], vb[c], vs[c], 5'(c));
            else clr_req(1);
            #1;
            check($sformatf("t3_ready_%0d", c), req_ready, (c < 5) ? 64'h2 : 64'h0);
            if (c >= 2) begin
                check($sformatf("t3_valid_%0d", c - 2), res_valid, 1);
                check($sformatf("t3_sum_%0d", c - 2), res_sum, esum[c-2]);
                check($sformatf("t3_cout_%0d", c - 2), res_cout, ecout[c-2]);
                check($sformatf("t3_ovf_%0d", c - 2), res_ovf, eovf[c-2]);
                check($sformatf("t3_dest_%0d", c - 2), res_dest, 64'(c - 2));
            end
            step();
        end

        // Backpressure with three requests pending; pointer starts at 2.
        res_ready = 1'b0;
        set_req(0, 64'h100, 64'h1, 1'b0, 5'd20);
        set_req(2, 64'h200, 64'h2, 1'b0, 5'd22);
        set_req(3, 64'h300, 64'h3, 1'b1, 5'd23);
        #1 check("t4_ready_a", req_ready, 4'b0100);
        step();
        clr_req(2);
        #1 check("t4_ready_b", req_ready, 4'b1000);
        step();
        clr_req(3);
        held_sum = 64'h202;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("t4_stall_ready_%0d", i), req_ready, 0);
            check($sformatf("t4_stall_valid_%0d", i), res_valid, 1);
            check($sformatf("t4_stall_slot_%0d", i), res_slot, 2);
            check($sformatf("t4_stall_sum_%0d", i), res_sum, held_sum);
            check($sformatf("t4_stall_dest_%0d", i), res_dest, 22);
            step();
        end
        res_ready = 1'b1;
        #1;
        check("t4_rel_ready", req_ready, 4'b0001);
        check("t4_rel_slot", res_slot, 2);
        step();
        clr_req(0);
        #1;
        check("t4_d1_valid", res_valid, 1);
        check("t4_d1_slot", res_slot, 3);
        check("t4_d1_sum", res_sum, 64'h2FD);
        check("t4_d1_ready", req_ready, 0);
        step();
        #1;
        check("t4_d2_valid", res_valid, 1);
        check("t4_d2_slot", res_slot, 0);
        check("t4_d2_sum", res_sum, 64'h101);
        step();
        #1 check("t4_empty", res_valid, 0);

        // Reset with both stages full; pointer would be 3 without it.
        res_ready = 1'b0;
        set_req(1, 64'h11, 64'h22, 1'b0, 5'd1);
        set_req(2, 64'h33, 64'h44, 1'b0, 5'd2);
        #1 check("t5_fill_a", req_ready, 4'b0010);
        step();
        clr_req(1);
        #1 check("t5_fill_b", req_ready, 4'b0100);
        step();
        clr_req(2);
        #1 check("t5_full_valid", res_valid, 1);
        rst = 1'b1;
        res_ready = 1'b1;
        set_req(1, 64'h1000, 64'h1, 1'b0, 5'd9);
        set_req(3, 64'h5, 64'h6, 1'b0, 5'd4);
        #1 check("t5_ready_in_rst", req_ready, 0);
        step();
        rst = 1'b0;
        #1;
        check("t5_post_valid", res_valid, 0);
        check("t5_post_sum", res_sum, 0);
        check("t5_post_slot", res_slot, 0);
        check("t5_post_ready", req_ready, 4'b0010);
        step();
        clr_req(1); clr_req(3);
        #1 check("t5_no_stale", res_valid, 0);
        step();
        check("t5_new_valid", res_valid, 1);
        check("t5_new_slot", res_slot, 1);
        check("t5_new_sum", res_sum, 64'h1001);
        check("t5_new_dest", res_dest, 9);
        step();
        #1 check("t5_empty", res_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_slot_arbiter.md
# add_slot_arbiter

Shares one 64-bit parallel-prefix adder among the VLIW issue slots that need integer add/subtract in the same bundle. Performs round-robin arbitration over the slot requests with per-slot valid/ready handshakes and registers the granted operands. Drives the existing prefix adder, unchanged. Returns sum, flags and the originating slot/destination tag through a 2-stage, back-pressurable pipeline.

## Interface
- NUM_SLOTS, 4, number of requesting issue slots (2..8)
- WIDTH, 64, operand width; must match the prefix adder
- DEST_W, 5, destination register tag width
- SLOT_W, clog2(NUM_SLOTS), slot index width (derived, not overridable)

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_SLOTS  per-slot request valid
- req_ready  out  NUM_SLOTS  per-slot accept; one-hot or zero
- req_a  in  NUM_SLOTS*WIDTH  operand A, slot i at [i*WIDTH +: WIDTH]
- req_b  in  NUM_SLOTS*WIDTH  operand B, same packing
- req_sub  in  NUM_SLOTS  1 = A-B, 0 = A+B
- req_dest  in  NUM_SLOTS*DEST_W  destination tag, carried through
- res_valid  out  1  result valid
- res_ready  in  1  result consumer accept
- res_slot  out  SLOT_W  slot that issued the result
- res_dest  out  DEST_W  carried destination tag
- res_sum  out  WIDTH  A+B or A-B, modulo 2^WIDTH
- res_cout  out  1  carry out (for sub: 1 = no borrow)
- res_ovf  out  1  signed overflow

## Operation
- Stage 0 (arbitrate): the round-robin pointer `rr_ptr` names the highest-priority slot. The grant goes to the first slot with req_valid=1, searching from rr_ptr upward with wrap-around. req_ready[g]=1 only for the granted slot and only when stage 1 can load.
- A transfer happens when req_valid[i] && req_ready[i]. On a transfer, rr_ptr <= (g+1) mod NUM_SLOTS. With no transfer, rr_ptr holds.
- Stage 1 (operand register, `s1_*`): stores a, b, sub, dest and slot. The adder input is a and (sub ? ~b : b), with carry-in = sub.
- Stage 2 (result register): captures the adder sum, cout, and ovf = (a[W-1]==b'[W-1]) && (sum[W-1]!=a[W-1]), where b' is the inverted-or-not B. Slot and dest pass through.
- Pipeline advance: stage 2 loads when !res_valid || res_ready. Stage 1 loads when it is empty or stage 2 loads.
- Stall (res_valid && !res_ready) freezes both stages and forces req_ready=0. All res_* outputs must stay stable while stalled.
- No valid requests: no transfer; bubbles propagate normally.
- Requests may drop valid without being granted. The arbiter holds no per-slot state other than rr_ptr.

## Timing
- Reset values: rr_ptr=0, all stage valids 0, res_valid=0, res_sum=0, res_cout=0, res_ovf=0, res_slot=0, res_dest=0.
- req_ready is combinational from req_valid, rr_ptr and stage occupancy. It has no path from res_ready other than through the stall condition.
- Latency: a transfer in cycle N gives res_valid=1 in cycle N+2 when there is no backpressure.
- Throughput: one result per cycle while res_ready=1 and requests are present.
- Reset asserted mid-operation clears both stages on the next edge. In-flight results are discarded and not reported.
- If rst and a request arrive in the same cycle, reset wins and no transfer occurs.
- Fairness: a continuously valid slot is granted within NUM_SLOTS transfers.

## Structure
- Package `add_arb_pkg` holds WIDTH/DEST_W defaults, the `add_req_t` struct (a, b, sub, dest, slot) and the `add_res_t` struct (sum, cout, ovf, dest, slot).
- Sub-module `rr_arbiter`, parameterised by NUM_SLOTS, takes req and ptr and outputs a one-hot grant and a grant index.
- The existing 64-bit prefix adder is instantiated between stage 1 and stage 2, with no changes to its carry levels.

## Test plan
- Slot 2 only, a=0x0000_0000_0000_0005, b=0x3, sub=0, dest=7, res_ready=1 -> res_valid exactly 2 cycles later with sum=0x8, cout=0, ovf=0, slot=2, dest=7; then rr_ptr=3.
- All 4 slots valid every cycle, res_ready=1 -> grant order 0,1,2,3,0,… with one result per cycle in the same slot order.
- Subtract: a=0x0, b=0x1, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFF, cout=0. Add: a=0x7FFF_FFFF_FFFF_FFFF, b=0x1 -> sum=0x8000_0000_0000_0000, ovf=1, cout=0. Add: a=b=0xFFFF_FFFF_FFFF_FFFF -> sum=…FFFE, cout=1.
- Hold res_ready=0 for 5 cycles with 3 requests pending -> at most 2 results buffered, req_ready=0 throughout, res_* stable. On release, results drain in order with no loss or duplication.
- Assert rst for one cycle while both stages are full -> next cycle res_valid=0 and rr_ptr=0, and the first grant afterwards goes to the lowest valid slot.
